// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: branch funct3 encodings, execute-stage FSM states
// and the default datapath width.
package riscv_pkg;

  localparam int DEFAULT_XLEN = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EVAL  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Execute-stage <-> branch resolver bundle: request/operands in, resolution
// pulses, redirect, flush and performance counters out.
interface branch_resolve_ctrl_if import riscv_pkg::*; #(
  parameter int XLEN  = DEFAULT_XLEN,
  parameter int CNT_W = 32
);

  logic             br_valid;
  logic             br_ready;
  logic             br_is_jal;
  logic             br_is_jalr;
  logic [2:0]       br_funct3;
  logic [XLEN-1:0]  br_pc;
  logic [XLEN-1:0]  br_imm;
  logic [XLEN-1:0]  br_rs1;
  logic [XLEN-1:0]  br_rs2;
  logic             kill;

  logic             res_valid;
  logic             res_taken;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             link_valid;
  logic [XLEN-1:0]  link_data;
  logic             misalign_exc;
  logic             illegal_exc;
  logic             flush_fe;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] taken_count;

  // The execute stage is the master; the resolver is the slave.
  modport master (
    output br_valid, br_is_jal, br_is_jalr, br_funct3,
           br_pc, br_imm, br_rs1, br_rs2, kill,
    input  br_ready, res_valid, res_taken, redirect_valid, redirect_pc,
           link_valid, link_data, misalign_exc, illegal_exc, flush_fe,
           br_count, taken_count
  );

  modport slave (
    input  br_valid, br_is_jal, br_is_jalr, br_funct3,
           br_pc, br_imm, br_rs1, br_rs2, kill,
    output br_ready, res_valid, res_taken, redirect_valid, redirect_pc,
           link_valid, link_data, misalign_exc, illegal_exc, flush_fe,
           br_count, taken_count
  );

endinterface

// File: rtl/branch_control.sv
// Shared branch comparator: equality and signed/unsigned less-than of rs1/rs2.
module branch_control import riscv_pkg::*; #(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            BrUn,
  output logic            BrEq,
  output logic            BrLt
);

  assign BrEq = (rs1 == rs2);
  assign BrLt = BrUn ? (rs1 < rs2) : ($signed(rs1) < $signed(rs2));

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Execute-stage branch/jump resolver: latch, compare, compute target, then
// redirect fetch and hold a front-end flush for FLUSH_CYCLES cycles.
module branch_resolve_ctrl import riscv_pkg::*; #(
  parameter int XLEN         = DEFAULT_XLEN,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input logic                  clk,
  input logic                  rst,
  branch_resolve_ctrl_if.slave bus
);

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  state_t          state;
  state_t          state_d;
  logic [3:0]      flush_cnt;
  logic [3:0]      flush_cnt_d;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] imm_q;
  logic [XLEN-1:0] rs1_q;
  logic [XLEN-1:0] rs2_q;
  logic [2:0]      funct3_q;
  logic            is_jal_q;
  logic            is_jalr_q;

  logic            br_eq;
  logic            br_lt;
  logic            accept;
  logic            resolve;
  logic            taken;
  logic            illegal;
  logic            misaligned;
  logic            redirect;
  logic [XLEN-1:0] target;

  branch_control #(.XLEN(XLEN)) u_branch_control (
    .rs1  (rs1_q),
    .rs2  (rs2_q),
    .BrUn (funct3_q[1]),
    .BrEq (br_eq),
    .BrLt (br_lt)
  );

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    if (is_jal_q || is_jalr_q) begin
      taken = 1'b1;
    end else begin
      case (funct3_q)
        F3_BEQ:  taken = br_eq;
        F3_BNE:  taken = !br_eq;
        F3_BLT:  taken = br_lt;
        F3_BGE:  taken = !br_lt;
        F3_BLTU: taken = br_lt;
        F3_BGEU: taken = !br_lt;
        default: illegal = 1'b1;
      endcase
    end
    // JALR clears bit 0 of the sum; everything else is PC-relative.
    target     = is_jalr_q ? ((rs1_q + imm_q) & ~XLEN'(1)) : (pc_q + imm_q);
    misaligned = taken && target[1];
    redirect   = taken && !misaligned;
  end

  always_comb begin
    state_d     = state;
    flush_cnt_d = flush_cnt;
    accept      = 1'b0;
    resolve     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.br_valid && !bus.kill) begin
          accept  = 1'b1;
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (bus.kill) begin
          state_d = ST_IDLE;
        end else begin
          resolve = 1'b1;
          if (redirect) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = FLUSH_INIT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_FLUSH: begin
        if (bus.kill || flush_cnt == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          flush_cnt_d = flush_cnt - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      flush_cnt <= 4'd0;
    end else begin
      state     <= state_d;
      flush_cnt <= flush_cnt_d;
    end
  end

  // Operands only need capturing on accept; the state reset alone discards them.
  always_ff @(posedge clk) begin
    if (accept) begin
      pc_q      <= bus.br_pc;
      imm_q     <= bus.br_imm;
      rs1_q     <= bus.br_rs1;
      rs2_q     <= bus.br_rs2;
      funct3_q  <= bus.br_funct3;
      is_jal_q  <= bus.br_is_jal;
      is_jalr_q <= bus.br_is_jalr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.res_valid      <= 1'b0;
      bus.res_taken      <= 1'b0;
      bus.redirect_valid <= 1'b0;
      bus.link_valid     <= 1'b0;
      bus.misalign_exc   <= 1'b0;
      bus.illegal_exc    <= 1'b0;
      bus.redirect_pc    <= '0;
      bus.link_data      <= '0;
      bus.br_count       <= '0;
      bus.taken_count    <= '0;
    end else begin
      bus.res_valid      <= resolve;
      bus.res_taken      <= resolve && redirect;
      bus.redirect_valid <= resolve && redirect;
      bus.link_valid     <= resolve && (is_jal_q || is_jalr_q);
      bus.misalign_exc   <= resolve && misaligned;
      bus.illegal_exc    <= resolve && illegal;
      if (resolve) begin
        bus.link_data <= pc_q + XLEN'(4);
        bus.br_count  <= bus.br_count + CNT_W'(1);
        if (redirect) begin
          bus.redirect_pc <= target;
          bus.taken_count <= bus.taken_count + CNT_W'(1);
        end
      end
    end
  end

  assign bus.br_ready = (state == ST_IDLE);
  assign bus.flush_fe = (state == ST_FLUSH);

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: a reference model pushes the
// expected resolution when a branch is offered; each test pops it at T+2.
module tb_branch_resolve_ctrl;
  import riscv_pkg::*;

  localparam int XLEN         = 32;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 4;

  typedef struct packed {
    logic             vld;
    logic             taken;
    logic             redirect;
    logic             link;
    logic             misalign;
    logic             illegal;
    logic [XLEN-1:0]  redirect_pc;
    logic [XLEN-1:0]  link_data;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] tk_cnt;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_resolve_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  branch_resolve_ctrl #(
    .XLEN         (XLEN),
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  res_t             exp_q[$];
  res_t             got_r;
  res_t             exp_r;
  logic [CNT_W-1:0] exp_br = '0;
  logic [CNT_W-1:0] exp_tk = '0;
  int               checks = 0;
  int               errors = 0;

  function automatic res_t observe();
    res_t r;
    r.vld         = bus.res_valid;
    r.taken       = bus.res_taken;
    r.redirect    = bus.redirect_valid;
    r.link        = bus.link_valid;
    r.misalign    = bus.misalign_exc;
    r.illegal     = bus.illegal_exc;
    r.redirect_pc = bus.redirect_valid ? bus.redirect_pc : '0;
    r.link_data   = bus.link_valid ? bus.link_data : '0;
    r.br_cnt      = bus.br_count;
    r.tk_cnt      = bus.taken_count;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.br_valid   = 1'b0;
    bus.br_is_jal  = 1'($urandom());
    bus.br_is_jalr = 1'($urandom());
    bus.br_funct3  = 3'($urandom());
    bus.br_pc      = $urandom();
    bus.br_imm     = $urandom();
    bus.br_rs1     = $urandom();
    bus.br_rs2     = $urandom();
  endtask

  // Drives one offer; when scored, the model result is queued for T+2.
  task automatic send(input logic jal, input logic jalr, input logic [2:0] f3,
                      input logic [31:0] pc, input logic [31:0] imm,
                      input logic [31:0] rs1, input logic [31:0] rs2,
                      input bit scored);
    res_t        e;
    logic        tk;
    logic        ill;
    logic        mis;
    logic [31:0] tgt;
    bus.br_valid   = 1'b1;
    bus.br_is_jal  = jal;
    bus.br_is_jalr = jalr;
    bus.br_funct3  = f3;
    bus.br_pc      = pc;
    bus.br_imm     = imm;
    bus.br_rs1     = rs1;
    bus.br_rs2     = rs2;
    if (scored) begin
      ill = 1'b0;
      tk  = 1'b0;
      if (jal || jalr) tk = 1'b1;
      else begin
        case (f3)
          3'b000: tk = (rs1 == rs2);
          3'b001: tk = (rs1 != rs2);
          3'b100: tk = ($signed(rs1) < $signed(rs2));
          3'b101: tk = ($signed(rs1) >= $signed(rs2));
          3'b110: tk = (rs1 < rs2);
          3'b111: tk = (rs1 >= rs2);
          default: ill = 1'b1;
        endcase
      end
      tgt           = jalr ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
      mis           = tk && tgt[1];
      e.vld         = 1'b1;
      e.taken       = tk && !mis;
      e.redirect    = tk && !mis;
      e.link        = jal || jalr;
      e.misalign    = mis;
      e.illegal     = ill;
      e.redirect_pc = e.redirect ? tgt : 32'h0;
      e.link_data   = e.link ? (pc + 32'd4) : 32'h0;
      exp_br        = exp_br + CNT_W'(1);
      if (e.redirect) exp_tk = exp_tk + CNT_W'(1);
      e.br_cnt      = exp_br;
      e.tk_cnt      = exp_tk;
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    bus.kill = 1'b0;
    idle_inputs();
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.br_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ready got=%b exp=1", bus.br_ready);
    end
    checks++;
    if ({bus.res_valid, bus.res_taken, bus.redirect_valid, bus.link_valid,
         bus.misalign_exc, bus.illegal_exc, bus.flush_fe} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL reset_pulses got=%b exp=0000000",
               {bus.res_valid, bus.res_taken, bus.redirect_valid, bus.link_valid,
                bus.misalign_exc, bus.illegal_exc, bus.flush_fe});
    end
    checks++;
    if ({bus.redirect_pc, bus.link_data} !== 64'h0) begin
      errors++;
      $display("[TB] FAIL reset_data got=%h/%h exp=0/0", bus.redirect_pc, bus.link_data);
    end
    checks++;
    if ({bus.br_count, bus.taken_count} !== 8'h0) begin
      errors++;
      $display("[TB] FAIL reset_counts got=%h/%h exp=0/0", bus.br_count, bus.taken_count);
    end
    step();
  endtask

  task automatic test_beq_taken();
    send(1'b0, 1'b0, F3_BEQ, 32'h100, 32'h20, 32'd5, 32'd5, 1'b1);
    step();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (bus.res_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL beq_early_result got=%b exp=0", bus.res_valid);
    end
    @(negedge clk);
    got_r = observe();
    exp_r = exp_q.pop_front();
    checks++;
    if (got_r !== exp_r) begin
      errors++;
      $display("[TB] FAIL beq_result got=%h exp=%h", got_r, exp_r);
    end
    checks++;
    if ({bus.flush_fe, bus.br_ready} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL beq_flush_t2 got=%b exp=10", {bus.flush_fe, bus.br_ready});
    end
    @(negedge clk);
    checks++;
    if ({bus.flush_fe, bus.br_ready, bus.redirect_valid} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL beq_flush_t3 got=%b exp=100",
               {bus.flush_fe, bus.br_ready, bus.redirect_valid});
    end
    @(negedge clk);
    checks++;
    if ({bus.flush_fe, bus.br_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL beq_ready_t4 got=%b exp=01", {bus.flush_fe, bus.br_ready});
    end
    step();
  endtask

  task automatic test_blt_bltu();
    send(1'b0, 1'b0, F3_BLT, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b1);
    step();
    idle_inputs();
    repeat (2) @(negedge clk);
    got_r = observe();
    exp_r = exp_q.pop_front();
    checks++;
    if (got_r !== exp_r) begin
      errors++;
      $display("[TB] FAIL blt_result got=%h exp=%h", got_r, exp_r);
    end
    repeat (2) @(negedge clk);
    step();
    send(1'b0, 1'b0, F3_BLTU, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b1);
    step();
    idle_inputs();
    repeat (2) @(negedge clk);
    got_r = observe();
    exp_r = exp_q.pop_front();
    checks++;
    if (got_r !== exp_r) begin
      errors++;
      $display("[TB] FAIL bltu_result got=%h exp=%h", got_r, exp_r);
    end
    checks++;
    if ({bus.br_ready, bus.flush_fe} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL bltu_ready_t2 got=%b exp=10", {bus.br_ready, bus.flush_fe});
    end
    step();
  endtask

  task automatic test_jalr_misalign();
    send(1'b0, 1'b1, 3'b000, 32'h300, 32'h0, 32'h203, 32'h0, 1'b1);
    step();
    idle_inputs();
    repeat (2) @(negedge clk);
    got_r = observe();
    exp_r = exp_q.pop_front();
    checks++;
    if (got_r !== exp_r) begin
      errors++;
      $display("[TB] FAIL jalr_misalign got=%h exp=%h", got_r, exp_r);
    end
    checks++;
    if ({bus.br_ready, bus.flush_fe} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL jalr_back_to_idle got=%b exp=10", {bus.br_ready, bus.flush_fe});
    end
    step();
  endtask

  task automatic test_illegal();
    for (int i = 0; i < 2; i++) begin
      send(1'b0, 1'b0, 3'(2 + i), 32'h400, 32'h8, 32'd7, 32'd7, 1'b1);
      step();
      idle_inputs();
      repeat (2) @(negedge clk);
      got_r = observe();
      exp_r = exp_q.pop_front();
      checks++;
      if (got_r !== exp_r) begin
        errors++;
        $display("[TB] FAIL illegal_f3_%0d got=%h exp=%h", 2 + i, got_r, exp_r);
      end
      step();
    end
  endtask

  task automatic test_kill();
    bus.kill = 1'b1;
    send(1'b0, 1'b0, F3_BNE, 32'h500, 32'h10, 32'd1, 32'd2, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.br_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL kill_idle_ready got=%b exp=1", bus.br_ready);
    end
    step();
    bus.kill = 1'b0;
    idle_inputs();
    @(negedge clk);
    checks++;
    if (bus.br_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL kill_idle_not_latched got=%b exp=1", bus.br_ready);
    end
    step();
    send(1'b0, 1'b0, F3_BNE, 32'h600, 32'h10, 32'd1, 32'd2, 1'b0);
    step();
    idle_inputs();
    bus.kill = 1'b1;
    step();
    bus.kill = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.res_valid, bus.redirect_valid, bus.flush_fe, bus.br_ready} !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL kill_eval_suppress got=%b exp=0001",
               {bus.res_valid, bus.redirect_valid, bus.flush_fe, bus.br_ready});
    end
    checks++;
    if ({bus.br_count, bus.taken_count} !== {exp_br, exp_tk}) begin
      errors++;
      $display("[TB] FAIL kill_eval_counts got=%h/%h exp=%h/%h",
               bus.br_count, bus.taken_count, exp_br, exp_tk);
    end
    send(1'b0, 1'b0, F3_BEQ, 32'h700, 32'h10, 32'd1, 32'd2, 1'b1);
    step();
    idle_inputs();
    repeat (2) @(negedge clk);
    got_r = observe();
    exp_r = exp_q.pop_front();
    checks++;
    if (got_r !== exp_r) begin
      errors++;
      $display("[TB] FAIL kill_back_to_back got=%h exp=%h", got_r, exp_r);
    end
    step();
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    repeat (2) step();
    rst    = 1'b0;
    exp_br = '0;
    exp_tk = '0;
    exp_q.delete();
    step();
    for (int i = 0; i < 16; i++) begin
      send(1'b1, 1'b0, 3'($urandom()), 32'(i) * 32'h100, 32'h10, $urandom(), $urandom(), 1'b1);
      step();
      idle_inputs();
      repeat (2) @(negedge clk);
      got_r = observe();
      exp_r = exp_q.pop_front();
      checks++;
      if (got_r !== exp_r) begin
        errors++;
        $display("[TB] FAIL jal_wrap_%0d got=%h exp=%h", i, got_r, exp_r);
      end
      repeat (2) step();
    end
    checks++;
    if ({bus.br_count, bus.taken_count} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL counter_wrap got=%h/%h exp=0/0", bus.br_count, bus.taken_count);
    end
  endtask

  task automatic test_rst_flush();
    send(1'b1, 1'b0, 3'b000, 32'h800, 32'h20, 32'h0, 32'h0, 1'b1);
    step();
    idle_inputs();
    step();
    rst = 1'b1;
    @(negedge clk);
    got_r = observe();
    exp_r = exp_q.pop_front();
    checks++;
    if (got_r !== exp_r || bus.flush_fe !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_rst_jal got=%h flush=%b exp=%h flush=1", got_r, bus.flush_fe, exp_r);
    end
    step();
    rst    = 1'b0;
    exp_br = '0;
    exp_tk = '0;
    @(negedge clk);
    checks++;
    if ({bus.flush_fe, bus.br_ready, bus.br_count, bus.taken_count} !== {2'b01, 8'h00}) begin
      errors++;
      $display("[TB] FAIL rst_in_flush got=%b/%b/%h/%h exp=0/1/0/0",
               bus.flush_fe, bus.br_ready, bus.br_count, bus.taken_count);
    end
    step();
    send(1'b0, 1'b0, F3_BNE, 32'h900, 32'h10, 32'd3, 32'd4, 1'b0);
    step();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.res_valid, bus.redirect_valid, bus.br_ready} !== 3'b001) begin
      errors++;
      $display("[TB] FAIL rst_in_eval got=%b exp=001",
               {bus.res_valid, bus.redirect_valid, bus.br_ready});
    end
    step();
  endtask

  initial begin
    test_reset();
    test_beq_taken();
    test_blt_bltu();
    test_jalr_misalign();
    test_illegal();
    test_kill();
    test_wrap();
    test_rst_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
Sequences branch and jump resolution for the RV32I core's execute stage.
- Accepts one branch/jump per handshake and latches its operands.
- Drives the shared branch_control comparator and resolves taken/not-taken from funct3.
- Computes the target, then issues a fetch redirect plus a timed front-end flush.
- Keeps wrap-around performance counters for branches resolved and branches taken.

Parameters:
XLEN, 32, datapath width of PC, operands and target.
FLUSH_CYCLES, 2, cycles flush_fe stays high after a taken redirect; legal range 1..15.
CNT_W, 32, width of the performance counters.

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
br_valid  in  1  execute stage offers a branch/jump
br_ready  out  1  block can accept; equals (state==IDLE)
br_is_jal  in  1  instruction is JAL
br_is_jalr  in  1  instruction is JALR
br_funct3  in  3  conditional-branch funct3; ignored for JAL/JALR
br_pc  in  XLEN  PC of the instruction
br_imm  in  XLEN  sign-extended immediate
br_rs1  in  XLEN  rs1 operand
br_rs2  in  XLEN  rs2 operand
kill  in  1  trap/higher-priority flush; aborts the in-flight branch
res_valid  out  1  one-cycle pulse: resolution result is valid
res_taken  out  1  resolved taken (held with res_valid)
redirect_valid  out  1  one-cycle pulse: fetch must load redirect_pc
redirect_pc  out  XLEN  redirect target
link_valid  out  1  pulse with res_valid for JAL/JALR
link_data  out  XLEN  br_pc+4 of the resolved jump
misalign_exc  out  1  pulse: taken target not 4-byte aligned
illegal_exc  out  1  pulse: conditional branch with funct3 010/011
flush_fe  out  1  flush IF/ID
br_count  out  CNT_W  branches/jumps resolved
taken_count  out  CNT_W  redirects issued

Behaviour:
Reset:
- state=IDLE; all pulses, flush_fe, redirect_pc, link_data and both counters are 0.
- br_ready=1 in the cycle after rst deasserts.
- rst mid-operation discards the latched branch; no pulse is emitted.

FSM states: IDLE, EVAL, FLUSH.
- IDLE: on br_valid&br_ready (cycle T), latch pc, imm, rs1, rs2, funct3, is_jal, is_jalr, then go to EVAL.
- EVAL (T+1):
  - Drive the internal branch_control instance from the latched rs1/rs2, with BrUn = funct3[1].
  - Taken rules:
    - BEQ 000 = BrEq; BNE 001 = !BrEq
    - BLT 100 = BrLt; BGE 101 = !BrLt
    - BLTU 110 = BrLt; BGEU 111 = !BrLt
    - JAL/JALR always taken.
    - funct3 010/011 (non-jump): illegal, not taken.
  - Target:
    - JALR: (rs1+imm) & ~1.
    - Otherwise: pc+imm.
    - Addition is modulo 2^XLEN; wrap is legal.
  - Misaligned: taken and target[1]!=0.
- Registered outputs at T+2:
  - res_valid=1.
  - res_taken = taken & !misaligned.
  - link_valid = is_jal|is_jalr.
  - link_data = pc+4, computed even if misaligned.
  - misalign_exc, illegal_exc per rules above.
  - redirect_valid = taken & !misaligned, with redirect_pc = target.
  - br_count+1 on every resolution; taken_count+1 iff redirect_valid.
- Next state from EVAL:
  - redirect → FLUSH, with flush_fe=1 for exactly FLUSH_CYCLES cycles starting at T+2.
  - otherwise → IDLE, so br_ready=1 at T+2.
- FLUSH:
  - Down-counter from FLUSH_CYCLES-1; go to IDLE when it reaches 0.
  - br_ready=1 at T+2+FLUSH_CYCLES.
- Latency: accept-to-result is exactly 2 cycles; throughput is one branch per 2 cycles (not taken) or per 2+FLUSH_CYCLES cycles (taken).

kill handling (priority: rst > kill > normal):
- In EVAL: no pulses, counters unchanged, next state IDLE.
- In FLUSH: flush_fe drops the next cycle, state goes to IDLE.
- In IDLE: suppresses acceptance that cycle; br_ready stays 1, and the offered branch is not latched.

Other rules:
- Counters wrap at 2^CNT_W with no saturation.
- Inputs are ignored outside the accept cycle.
- All pulses last exactly one cycle.

Decomposition:
- Shared package riscv_pkg holds:
  - funct3 localparams F3_BEQ/BNE/BLT/BGE/BLTU/BGEU;
  - state encoding ST_IDLE=2'd0, ST_EVAL=2'd1, ST_FLUSH=2'd2;
  - XLEN default.
- Exactly one sub-module: an instance of the existing branch_control comparator.
- Taken decode, target adder and FSM stay inline.

Test Plan:
- BEQ, rs1=rs2=5, pc=0x100, imm=0x20 → T+2: res_taken=1, redirect_pc=0x120; flush_fe high for 2 cycles; br_ready at T+4; taken_count=1.
- BLT vs BLTU, rs1=0xFFFFFFFF, rs2=1 → BLT taken, BLTU not taken (res_valid=1, no redirect, br_ready at T+2).
- JALR, rs1=0x203, imm=0 → target 0x202, misalign_exc=1, no redirect, link_data=pc+4, state back to IDLE.
- funct3=010 → illegal_exc=1, res_taken=0; br_count increments, taken_count does not.
- kill asserted during EVAL of a taken BNE → no res_valid/redirect, counters unchanged; a back-to-back branch is accepted the next cycle.
- Counter wrap with CNT_W=4: 16 taken JALs → taken_count returns to 0; rst asserted during FLUSH → flush_fe=0 and br_ready=1 the cycle after rst deasserts.
